// File: rtl/integrator.sv
// Saturating signed integrator: accumulates data_in on each data_en strobe,
// clamping the running sum to the representable range of MSB+1 bits.
// The new sum appears one clock after the strobe, together with
// data_en_out and the clamp flag sat_out.
module integrator #(
  parameter int MSB = 31
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [MSB:0] data_in,
  input  logic         data_en,
  input  logic         clear,
  output logic [MSB:0] data_out,
  output logic         data_en_out,
  output logic         sat_out
);

  localparam logic signed [MSB:0] MAX_VAL = {1'b0, {MSB{1'b1}}};
  localparam logic signed [MSB:0] MIN_VAL = {1'b1, {MSB{1'b0}}};

  // Clamp a one-bit-wider sum back into MSB+1 bits.
  // The two top bits disagree exactly when the sum left the range.
  function automatic logic signed [MSB:0] sat_sum(input logic signed [MSB+1:0] s);
    logic signed [MSB:0] r;
    if (s[MSB+1] != s[MSB]) begin
      r = s[MSB+1] ? MIN_VAL : MAX_VAL;
    end else begin
      r = s[MSB:0];
    end
    return r;
  endfunction

  // Report whether sat_sum() would clamp this sum.
  function automatic logic sat_hit(input logic signed [MSB+1:0] s);
    return s[MSB+1] != s[MSB];
  endfunction

  logic signed [MSB:0]   din_p0;
  logic signed [MSB:0]   acc_p1;
  logic                  sat_p1;
  logic                  vld_p1;
  logic signed [MSB+1:0] sum_p0;
  logic signed [MSB:0]   acc_nxt;
  logic                  sat_nxt;
  logic                  vld_nxt;

  assign din_p0 = data_in;

  // ---- stage p0: widen, add and clamp against the current accumulator ----
  // Sign-extended sum at MSB+2 bits so no overflow can be lost before clamping.
  always_comb begin
    sum_p0 = {acc_p1[MSB], acc_p1} + {din_p0[MSB], din_p0};
  end

  // Select the next accumulator, flag and strobe; clear takes precedence
  // over accumulation, and clear with a sample restarts from that sample.
  always_comb begin
    acc_nxt = acc_p1;
    sat_nxt = sat_p1;
    vld_nxt = 1'b0;
    if (clear && data_en) begin
      acc_nxt = din_p0;
      sat_nxt = 1'b0;
      vld_nxt = 1'b1;
    end else if (clear) begin
      acc_nxt = '0;
      sat_nxt = 1'b0;
      vld_nxt = 1'b0;
    end else if (data_en) begin
      acc_nxt = sat_sum(sum_p0);
      sat_nxt = sat_hit(sum_p0);
      vld_nxt = 1'b1;
    end
  end

  // ---- stage p1: registered accumulator, clamp flag and output strobe ----
  // Reset clears everything immediately so no in-flight update survives it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_p1 <= '0;
      sat_p1 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      acc_p1 <= acc_nxt;
      sat_p1 <= sat_nxt;
      vld_p1 <= vld_nxt;
    end
  end

  assign data_out    = acc_p1;
  assign data_en_out = vld_p1;
  assign sat_out     = sat_p1;

endmodule

// File: doc/integrator.md
INTEGRATOR -- requirements
Module: integrator

Interface
REQ-001 The block SHALL have parameter MSB, default 31, meaning the index of the sign bit of data_in and data_out (width MSB+1).
REQ-002 Port clk SHALL be an input, 1 bit wide; it is the single clock, and all state updates on its rising edge.
REQ-003 Port rst SHALL be an input, 1 bit wide; reset is asynchronous and active-high.
REQ-004 Port data_in SHALL be an input, MSB+1 bits wide, carrying a two's-complement signed sample (typically a difference produced upstream).
REQ-005 Port data_en SHALL be an input, 1 bit wide; it is a one-cycle sample strobe, and data_in is valid while it is high.
REQ-006 Port clear SHALL be an input, 1 bit wide, acting as a synchronous accumulator clear.
REQ-007 Port data_out SHALL be an output, MSB+1 bits wide, holding the registered two's-complement running sum.
REQ-008 Port data_en_out SHALL be an output, 1 bit wide, giving a one-cycle strobe that marks an updated data_out.
REQ-009 Port sat_out SHALL be an output, 1 bit wide; it is high when the most recent update was clamped.

Function
REQ-010 The internal accumulator acc SHALL be MSB+1 bits wide, signed, and data_out SHALL always equal acc.
REQ-011 On a rising edge with data_en=1 and clear=0, the next acc SHALL be sat(acc + data_in):
- the sum is computed at MSB+2 bits with sign extension, then clamped to the range [-2^MSB, 2^MSB-1].
REQ-012 sat() SHALL behave as follows:
- positive overflow yields 2^MSB-1;
- negative overflow yields -2^MSB;
- otherwise the exact sum passes through.
REQ-013 On every update edge, sat_out SHALL be set to 1 if the clamp engaged and to 0 otherwise, and it SHALL hold between updates.
REQ-014 data_en_out SHALL be 1 for exactly the cycle after each accepted data_en; latency is 1 clock from data_en to the new data_out together with data_en_out.
REQ-015 Back-to-back data_en (every cycle) SHALL be accepted without stalls, each sample producing one data_en_out.
REQ-016 With data_en=0 and clear=0, acc and sat_out SHALL hold, and data_en_out SHALL be 0.
REQ-017 With clear=1 and data_en=0, acc SHALL become 0, sat_out SHALL become 0 and data_en_out SHALL become 0 on the next edge.
REQ-018 With clear=1 and data_en=1 in the same cycle, the integration SHALL restart from that sample:
- acc SHALL become data_in (no clamp is possible);
- sat_out SHALL become 0;
- data_en_out SHALL become 1.
REQ-019 The first sample after reset or clear SHALL produce a valid output; no priming sample is required.
REQ-020 Feeding successive differences d[n] = x[n] - x[n-1] SHALL reconstruct x[n] - x[start] exactly while no clamp occurs.
REQ-021 Once acc is clamped, later samples of the opposite sign SHALL integrate away from the rail normally, with no sticky state.

Reset
REQ-022 While rst=1, asynchronously and regardless of clk, data_out SHALL be 0, data_en_out SHALL be 0 and sat_out SHALL be 0.
REQ-023 rst=1 SHALL override clear and data_en, and an update in flight SHALL be discarded.
REQ-024 After rst deasserts, the first edge with data_en=1 SHALL load acc = data_in.

Verification
REQ-025 Accumulate (MSB=31): after reset, send data_en pulses with data_in 5, then 3, then -2 -> data_out reads 5, 8, 6 on successive data_en_out strobes, sat_out=0 throughout.
REQ-026 Positive saturation (MSB=7): acc=120, then data_in=10 -> data_out=127 with sat_out=1; then data_in=-7 -> data_out=120 with sat_out=0.
REQ-027 Negative saturation (MSB=7): acc=-100, then data_in=-100 -> data_out=-128 with sat_out=1; then data_in=0 -> data_out=-128 with sat_out=0.
REQ-028 Clear plus sample: acc=50 and clear=1 with data_en=1 and data_in=9 in the same cycle -> next cycle data_out=9, data_en_out=1; clear alone -> data_out=0, data_en_out=0.
REQ-029 Mid-stream reset: with data_en high every cycle, assert rst between edges -> outputs go to 0 immediately without a clock edge; after release, data_in=4 -> data_out=4.
REQ-030 Inverse check: feed random x[n] through an upstream difference stage into this block, with no clamping -> data_out equals x[n] - x[0] on every data_en_out.
